// File: rtl/regfile_cmd_ctrl_pkg.sv
// Shared opcode and FSM state encodings for the register-file command controller.
package regfile_cmd_ctrl_pkg;

    localparam int SIZE_DEF  = 16;
    localparam int DEPTH_DEF = 8;

    typedef enum logic [1:0] {
        OP_LOAD  = 2'b00,
        OP_ADD   = 2'b01,
        OP_SUB   = 2'b10,
        OP_CLEAR = 2'b11
    } cmd_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_EXEC  = 2'b01,
        ST_CLEAR = 2'b10,
        ST_FIN   = 2'b11
    } state_e;

endpackage

// File: rtl/regfile_cmd_ctrl_if.sv
// Command handshake plus external regfile port bundle.
interface regfile_cmd_ctrl_if #(
    parameter int SIZE  = 16,
    parameter int DEPTH = 8
);
    localparam int AW = $clog2(DEPTH);

    logic            cmd_valid;
    logic            cmd_ready;
    logic [1:0]      cmd_op;
    logic [AW-1:0]   cmd_rd;
    logic [AW-1:0]   cmd_rs0;
    logic [AW-1:0]   cmd_rs1;
    logic [SIZE-1:0] cmd_imm;
    logic            done;
    logic [SIZE-1:0] result;
    logic            carry;
    logic [AW-1:0]   rf_waddr;
    logic [SIZE-1:0] rf_wdata;
    logic            rf_we;
    logic [AW-1:0]   rf_raddr0;
    logic [AW-1:0]   rf_raddr1;
    logic [SIZE-1:0] rf_rdata0;
    logic [SIZE-1:0] rf_rdata1;

    // Host and regfile side: issues commands, returns read data
    modport master (
        output cmd_valid, cmd_op, cmd_rd, cmd_rs0, cmd_rs1, cmd_imm,
        output rf_rdata0, rf_rdata1,
        input  cmd_ready, done, result, carry,
        input  rf_waddr, rf_wdata, rf_we, rf_raddr0, rf_raddr1
    );

    // Controller side
    modport slave (
        input  cmd_valid, cmd_op, cmd_rd, cmd_rs0, cmd_rs1, cmd_imm,
        input  rf_rdata0, rf_rdata1,
        output cmd_ready, done, result, carry,
        output rf_waddr, rf_wdata, rf_we, rf_raddr0, rf_raddr1
    );

endinterface

// File: rtl/regfile_cmd_ctrl.sv
// Register-file command controller: LOAD/ADD/SUB in one write cycle, CLEAR sweeps all entries.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | cmd_ready=1, waiting for a command handshake
// ST_EXEC  | single write cycle for LOAD/ADD/SUB (reads use latched rs0/rs1)
// ST_CLEAR | writes 0 to address cnt_q, one entry per cycle, ascending
// ST_FIN   | done pulse, result/carry held, then back to ST_IDLE
module regfile_cmd_ctrl
    import regfile_cmd_ctrl_pkg::*;
#(
    parameter int SIZE  = SIZE_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    regfile_cmd_ctrl_if.slave bus
);
    localparam int            AW        = $clog2(DEPTH);
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    state_e          state_q, state_d;
    cmd_op_e         op_q, op_d;
    logic [AW-1:0]   rd_q, rd_d, rs0_q, rs0_d, rs1_q, rs1_d, cnt_q, cnt_d;
    logic [SIZE-1:0] imm_q, imm_d, result_q, result_d;
    logic            carry_q, carry_d, done_q, done_d, we_q, we_d;

    logic            handshake;
    logic [SIZE:0]   sum_w, diff_w;
    logic [SIZE-1:0] wdata_w;
    logic            carry_w;

    assign handshake = bus.cmd_valid && (state_q == ST_IDLE);

    // Write data and carry for the current write cycle; zero outside EXEC (CLEAR writes 0)
    always_comb begin
        sum_w   = {1'b0, bus.rf_rdata0} + {1'b0, bus.rf_rdata1};
        diff_w  = {1'b0, bus.rf_rdata0} - {1'b0, bus.rf_rdata1};
        wdata_w = '0;
        carry_w = 1'b0;
        if (state_q == ST_EXEC) begin
            case (op_q)
                OP_LOAD: wdata_w = imm_q;
                OP_ADD: begin
                    wdata_w = sum_w[SIZE-1:0];
                    carry_w = sum_w[SIZE];
                end
                OP_SUB: begin
                    wdata_w = diff_w[SIZE-1:0];
                    carry_w = ~diff_w[SIZE];
                end
                default: ;
            endcase
        end
    end

    // Next-state, command latching, clear counter and registered status
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        rd_d     = rd_q;
        rs0_d    = rs0_q;
        rs1_d    = rs1_q;
        imm_d    = imm_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        carry_d  = carry_q;
        case (state_q)
            ST_IDLE: begin
                if (handshake) begin
                    op_d    = cmd_op_e'(bus.cmd_op);
                    rd_d    = bus.cmd_rd;
                    rs0_d   = bus.cmd_rs0;
                    rs1_d   = bus.cmd_rs1;
                    imm_d   = bus.cmd_imm;
                    cnt_d   = '0;
                    state_d = (cmd_op_e'(bus.cmd_op) == OP_CLEAR) ? ST_CLEAR : ST_EXEC;
                end
            end
            ST_EXEC:  state_d = ST_FIN;
            ST_CLEAR: begin
                if (cnt_q == LAST_ADDR) begin
                    cnt_d   = '0;
                    state_d = ST_FIN;
                end else begin
                    cnt_d = cnt_q + AW'(1);
                end
            end
            default:  state_d = ST_IDLE;
        endcase
        if (we_q) begin
            result_d = wdata_w;
            carry_d  = carry_w;
        end
        we_d   = (state_d == ST_EXEC) || (state_d == ST_CLEAR);
        done_d = (state_d == ST_FIN);
    end

    // State and output registers; reset aborts any command in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            op_q     <= OP_LOAD;
            rd_q     <= '0;
            rs0_q    <= '0;
            rs1_q    <= '0;
            imm_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
            done_q   <= 1'b0;
            we_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            rd_q     <= rd_d;
            rs0_q    <= rs0_d;
            rs1_q    <= rs1_d;
            imm_q    <= imm_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            done_q   <= done_d;
            we_q     <= we_d;
        end
    end

    assign bus.cmd_ready = (state_q == ST_IDLE);
    assign bus.done      = done_q;
    assign bus.result    = result_q;
    assign bus.carry     = carry_q;
    assign bus.rf_we     = we_q;
    assign bus.rf_wdata  = wdata_w;
    assign bus.rf_waddr  = (state_q == ST_EXEC)  ? rd_q  :
                           (state_q == ST_CLEAR) ? cnt_q : '0;
    assign bus.rf_raddr0 = (state_q == ST_EXEC) ? rs0_q : '0;
    assign bus.rf_raddr1 = (state_q == ST_EXEC) ? rs1_q : '0;

endmodule

// File: doc/regfile_cmd_ctrl.md
REGFILE_CMD_CTRL -- requirements
Module: regfile_cmd_ctrl

Interface
REQ-001 SHALL have parameter SIZE, default 16, data word width, matching the regfile entry width.
REQ-002 SHALL have parameter DEPTH, default 8, regfile entry count; AW = $clog2(DEPTH).
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port cmd_valid  input  1  command request.
REQ-006 SHALL have port cmd_ready  output  1  controller accepts a command this cycle.
REQ-007 SHALL have port cmd_op  input  2  opcode: 00 LOAD, 01 ADD, 10 SUB, 11 CLEAR.
REQ-008 SHALL have ports cmd_rd, cmd_rs0, cmd_rs1  input  AW each  destination and source addresses.
REQ-009 SHALL have port cmd_imm  input  SIZE  immediate for LOAD.
REQ-010 SHALL have port done  output  1  one-cycle completion pulse.
REQ-011 SHALL have port result  output  SIZE  last written value; valid when done=1.
REQ-012 SHALL have port carry  output  1  ADD carry-out / SUB no-borrow; valid when done=1.
REQ-013 SHALL have ports rf_waddr (AW), rf_wdata (SIZE), rf_we (1)  outputs  regfile write port.
REQ-014 SHALL have ports rf_raddr0, rf_raddr1  output  AW  regfile read addresses.
REQ-015 SHALL have ports rf_rdata0, rf_rdata1  input  SIZE  regfile combinational read data.

Function
REQ-016 SHALL implement FSM states IDLE, EXEC, CLEAR, FIN.
REQ-017 cmd_ready SHALL equal 1 only in IDLE; handshake = cmd_valid & cmd_ready; all cmd_* fields latched on handshake.
REQ-018 IDLE SHALL go to CLEAR on handshake with op 11, to EXEC on any other op, else stay in IDLE.
REQ-019 EXEC (exactly one cycle) SHALL drive rf_raddr0/1 = latched rs0/rs1, rf_we=1, rf_waddr=rd, rf_wdata = imm (LOAD), rdata0+rdata1 mod 2^SIZE (ADD), rdata0-rdata1 mod 2^SIZE (SUB); then go to FIN.
REQ-020 ADD carry SHALL be bit SIZE of the (SIZE+1)-bit sum; SUB carry SHALL be 1 when rdata0 >= rdata1; LOAD and CLEAR carry SHALL be 0.
REQ-021 CLEAR SHALL write 0 to addresses 0..DEPTH-1 in ascending order, one per cycle, rf_we=1 for exactly DEPTH cycles, counter wrapping to 0 after DEPTH-1, then go to FIN.
REQ-022 FIN SHALL assert done=1 for one cycle with result/carry held; then go to IDLE; cmd_ready=0 in FIN.
REQ-023 result and carry SHALL be registered at the last write cycle and held until the next write cycle; CLEAR result SHALL be 0.
REQ-024 Latency: handshake at edge T -> write at cycle T+1 -> done at cycle T+2 (LOAD/ADD/SUB); CLEAR done at cycle T+DEPTH+1.
REQ-025 rd equal to rs0 or rs1 SHALL use the pre-write value (regfile updates at the edge ending EXEC).
REQ-026 Outside EXEC/CLEAR, rf_we SHALL be 0 and rf_raddr0/1 SHALL be 0.
REQ-027 cmd_valid in non-IDLE states SHALL be ignored; no queuing.

Reset
REQ-028 rst_n low SHALL immediately force IDLE, counter=0, done=0, result=0, carry=0, rf_we=0, independent of clk.
REQ-029 Reset mid-EXEC or mid-CLEAR SHALL abort; no further writes; first cmd_ready=1 in the first cycle after rst_n rises.

Structure
REQ-030 Opcode encodings and FSM state encodings SHALL live in a shared package.
REQ-031 Single module; no sub-modules; regfile instantiated externally by the integrator.

Verification
REQ-032 LOAD rd=3 imm=0x1234 -> rf_we=1, waddr=3, wdata=0x1234 at T+1; done at T+2, result=0x1234, carry=0.
REQ-033 r1=0xFFFF, r2=0x0002, ADD rd=1 rs0=1 rs1=2 -> wdata=0x0001, carry=1; subsequent read of r1 = 0x0001.
REQ-034 r4=5, r5=7, SUB rd=6 rs0=4 rs1=5 -> wdata=0xFFFE, carry=0.
REQ-035 CLEAR with DEPTH=8 -> 8 consecutive writes of 0 to addresses 0..7, done at T+9, all entries read 0.
REQ-036 cmd_valid held high through EXEC and FIN -> exactly one command accepted per IDLE visit.
REQ-037 rst_n low during CLEAR at address 3 -> rf_we drops immediately, addresses 4..7 keep prior values, done never pulses.
